hub_arbiter: RTL and testbench

HUB_ARBITER -- requirements
Module: hub_arbiter

---
 rtl/hub_pkg.sv | 23 ++
 rtl/hub_rx_capture.sv | 91 +++++++++
 rtl/hub_arbiter.sv | 140 ++++++++++++++
 tb/tb_hub_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/hub_pkg.sv
// hub_pkg: shared constants and state encodings for the four-port serial hub.
//   SFD     : default start-of-frame delimiter, first-received bit is the MSB
//   DATA_W  : default payload bits per frame
//   N_PORTS : number of serial ports on the hub
//   rx_state_t / tx_state_t : receive and transmit FSM encodings
package hub_pkg;

   localparam logic [7:0] SFD     = 8'b10101011;
   localparam int         DATA_W  = 8;
   localparam int         N_PORTS = 4;

   typedef enum logic {
      RX_HUNT    = 1'b0,
      RX_CAPTURE = 1'b1
   } rx_state_t;

   typedef enum logic [1:0] {
      TX_IDLE = 2'd0,
      TX_SEND = 2'd1,
      TX_GAP  = 2'd2
   } tx_state_t;

endpackage

// File: rtl/hub_rx_capture.sv
// hub_rx_capture: per-port receiver. Hunts for the SFD in an 8-bit history,
// then captures DATA_W payload bits MSB first and posts them as a pending frame.
//   clk     : clock
//   reset   : synchronous active-low reset
//   rx      : serial receive line, one bit per clock
//   clr     : arbiter takes the pending frame on this edge
//   pending : a captured frame is waiting to be forwarded
//   frame   : captured payload, stable while pending
//   drop    : one-cycle pulse when a completed frame is discarded
module hub_rx_capture #(
   parameter logic [7:0] SFD    = hub_pkg::SFD,
   parameter int         DATA_W = hub_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   input  logic              clr,
   output logic              pending,
   output logic [DATA_W-1:0] frame,
   output logic              drop
);
   import hub_pkg::*;

   localparam int CNT_W = $clog2(DATA_W + 1);

   rx_state_t         state, state_nxt;
   logic [7:0]        hist;
   logic [7:0]        hist_nxt;
   logic [DATA_W-1:0] shreg;
   logic [DATA_W-1:0] shreg_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              last_bit;

   assign hist_nxt  = (hist << 1) | 8'(rx);
   assign shreg_nxt = (shreg << 1) | DATA_W'(rx);

   always_comb begin
      last_bit = (state == RX_CAPTURE) && (cnt == CNT_W'(DATA_W - 1));
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= RX_HUNT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         RX_HUNT:    if (hist_nxt == SFD) state_nxt = RX_CAPTURE;
         RX_CAPTURE: if (last_bit)        state_nxt = RX_HUNT;
         default:    state_nxt = RX_HUNT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         hist    <= '0;
         shreg   <= '0;
         cnt     <= '0;
         frame   <= '0;
         pending <= 1'b0;
         drop    <= 1'b0;
      end else begin
         drop <= 1'b0;
         // A grant and a new completion on the same edge: the set below wins,
         // so the old buffer leaves and the new frame becomes pending.
         if (clr) pending <= 1'b0;
         case (state)
            RX_HUNT: begin
               hist <= hist_nxt;
               cnt  <= '0;
            end
            RX_CAPTURE: begin
               shreg <= shreg_nxt;
               cnt   <= cnt + 1'b1;
               if (last_bit) begin
                  hist <= '0;
                  if (pending && !clr) begin
                     drop <= 1'b1;
                  end else begin
                     frame   <= shreg_nxt;
                     pending <= 1'b1;
                  end
               end
            end
            default: hist <= '0;
         endcase
      end
   end

endmodule

// File: rtl/hub_arbiter.sv
// hub_arbiter: four-port serial hub. Each port captures SFD-delimited frames;
// a round-robin arbiter forwards one pending frame at a time to every port
// except its source, followed by GAP forced idle cycles.
//   clk      : clock
//   reset    : synchronous active-low reset
//   rx0..rx3 : serial receive lines
//   tx0..tx3 : serial transmit lines (source port held at 0)
//   busy     : frame or trailing gap in progress
//   src      : port being forwarded, valid while busy
//   drop     : per-port one-cycle pulse on a discarded frame
module hub_arbiter #(
   parameter logic [7:0] SFD    = hub_pkg::SFD,
   parameter int         DATA_W = hub_pkg::DATA_W,
   parameter int         GAP    = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx0,
   input  logic       rx1,
   input  logic       rx2,
   input  logic       rx3,
   output logic       tx0,
   output logic       tx1,
   output logic       tx2,
   output logic       tx3,
   output logic       busy,
   output logic [1:0] src,
   output logic [3:0] drop
);
   import hub_pkg::*;

   localparam int FRAME_W = 8 + DATA_W;
   localparam int CNT_MAX = (FRAME_W > GAP) ? FRAME_W : GAP;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   logic [N_PORTS-1:0] rx_vec;
   logic [N_PORTS-1:0] pending;
   logic [N_PORTS-1:0] clr;
   logic [N_PORTS-1:0] tx_vec;
   logic [DATA_W-1:0]  frames [N_PORTS];

   tx_state_t          state, state_nxt;
   logic [FRAME_W-1:0] txsr;
   logic [CNT_W-1:0]   cnt;
   logic [1:0]         last;
   logic [1:0]         gnt_idx;
   logic               gnt_ok;

   assign rx_vec = {rx3, rx2, rx1, rx0};

   for (genvar g = 0; g < N_PORTS; g++) begin : g_rx
      hub_rx_capture #(
         .SFD    (SFD),
         .DATA_W (DATA_W)
      ) u_rx (
         .clk     (clk),
         .reset   (reset),
         .rx      (rx_vec[g]),
         .clr     (clr[g]),
         .pending (pending[g]),
         .frame   (frames[g]),
         .drop    (drop[g])
      );
   end

   // Search starts one past the last granted port; the last port itself is
   // checked last, which gives it lowest priority.
   always_comb begin
      gnt_ok  = 1'b0;
      gnt_idx = last;
      for (int k = 1; k <= N_PORTS; k++) begin
         if (!gnt_ok && pending[2'(last + 2'(k))]) begin
            gnt_ok  = 1'b1;
            gnt_idx = 2'(last + 2'(k));
         end
      end
   end

   always_comb begin
      clr = '0;
      if (state == TX_IDLE && gnt_ok) clr[gnt_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!reset) state <= TX_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         TX_IDLE: if (gnt_ok) state_nxt = TX_SEND;
         TX_SEND: if (cnt == CNT_W'(FRAME_W - 1)) state_nxt = (GAP == 0) ? TX_IDLE : TX_GAP;
         TX_GAP:  if (cnt == CNT_W'(GAP - 1))     state_nxt = TX_IDLE;
         default: state_nxt = TX_IDLE;
      endcase
   end

   always_comb begin
      tx_vec = '0;
      busy   = (state != TX_IDLE);
      if (state == TX_SEND) begin
         tx_vec      = {N_PORTS{txsr[FRAME_W-1]}};
         tx_vec[src] = 1'b0;
      end
   end

   assign tx0 = tx_vec[0];
   assign tx1 = tx_vec[1];
   assign tx2 = tx_vec[2];
   assign tx3 = tx_vec[3];

   // Reset pointer of 3 makes port 0 the first candidate after reset.
   always_ff @(posedge clk) begin
      if (!reset) begin
         txsr <= '0;
         cnt  <= '0;
         src  <= 2'd0;
         last <= 2'd3;
      end else begin
         case (state)
            TX_IDLE: begin
               cnt <= '0;
               if (gnt_ok) begin
                  txsr <= {SFD, frames[gnt_idx]};
                  src  <= gnt_idx;
                  last <= gnt_idx;
               end
            end
            TX_SEND: begin
               txsr <= txsr << 1;
               cnt  <= (cnt == CNT_W'(FRAME_W - 1)) ? '0 : cnt + 1'b1;
            end
            TX_GAP:  cnt <= cnt + 1'b1;
            default: cnt <= '0;
         endcase
      end
   end

endmodule

// File: tb/tb_hub_arbiter.sv
// tb_hub_arbiter: directed scenarios for hub_arbiter (SFD=AB, DATA_W=8, GAP=2).
// Stimulus row i is driven after negedge i and sampled at the following
// posedge P_i; log row i is captured at negedge i, i.e. the state after P_(i-1).
// A frame whose first bit is at row s completes at P_(s+15), is granted at
// P_(s+16) when idle, and its first SFD bit shows at log row s+17.
module tb_hub_arbiter;

   localparam int MAXC = 96;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx0, rx1, rx2, rx3;
   logic       tx0, tx1, tx2, tx3;
   logic       busy;
   logic [1:0] src;
   logic [3:0] drop;

   int n_cmp = 0;
   int n_bad = 0;

   logic [3:0] stim     [MAXC];
   logic       stim_rst [MAXC];
   logic [3:0] tx_log   [MAXC];
   logic       busy_log [MAXC];
   logic [1:0] src_log  [MAXC];
   logic [3:0] drop_log [MAXC];

   hub_arbiter #(
      .SFD    (8'b10101011),
      .DATA_W (8),
      .GAP    (2)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .rx0   (rx0),
      .rx1   (rx1),
      .rx2   (rx2),
      .rx3   (rx3),
      .tx0   (tx0),
      .tx1   (tx1),
      .tx2   (tx2),
      .tx3   (tx3),
      .busy  (busy),
      .src   (src),
      .drop  (drop)
   );

   always #5 clk = ~clk;

   task automatic clear_stim();
      for (int i = 0; i < MAXC; i++) begin
         stim[i]     = 4'b0000;
         stim_rst[i] = 1'b1;
      end
   endtask

   task automatic put_frame(input int p, input int start, input logic [7:0] pay);
      logic [15:0] f;
      f = {8'b10101011, pay};
      for (int j = 0; j < 16; j++) stim[start + j][p] = f[15 - j];
   endtask

   task automatic do_reset();
      reset = 1'b0;
      {rx3, rx2, rx1, rx0} = 4'b0000;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tx_log[i]   = {tx3, tx2, tx1, tx0};
         busy_log[i] = busy;
         src_log[i]  = src;
         drop_log[i] = drop;
         reset                = stim_rst[i];
         {rx3, rx2, rx1, rx0} = stim[i];
      end
      reset = 1'b1;
      {rx3, rx2, rx1, rx0} = 4'b0000;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      {rx3, rx2, rx1, rx0} = 4'b1111;
      repeat (3) @(negedge clk);
      n_cmp++; if ({tx3, tx2, tx1, tx0} !== 4'b0000) begin n_bad++; $display("FAIL reset_tx: got %b expected 0000", {tx3, tx2, tx1, tx0}); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_cmp++; if (src !== 2'd0) begin n_bad++; $display("FAIL reset_src: got %0d expected 0", src); end
      n_cmp++; if (drop !== 4'b0000) begin n_bad++; $display("FAIL reset_drop: got %b expected 0000", drop); end
   endtask

   // Single frame on rx0, payload 00001111.
   task automatic test_single();
      logic [15:0] f;
      logic [3:0]  etx;
      logic        ebusy;
      do_reset(); clear_stim();
      put_frame(0, 0, 8'b00001111);
      run(40);
      f = 16'hAB0F;
      for (int i = 0; i < 40; i++) begin
         etx   = (i >= 17 && i <= 32 && f[15 - (i - 17)]) ? 4'b1110 : 4'b0000;
         ebusy = (i >= 17 && i <= 34);
         n_cmp++; if (tx_log[i] !== etx) begin n_bad++; $display("FAIL single_tx cyc %0d: got %b expected %b", i, tx_log[i], etx); end
         n_cmp++; if (busy_log[i] !== ebusy) begin n_bad++; $display("FAIL single_busy cyc %0d: got %b expected %b", i, busy_log[i], ebusy); end
         n_cmp++; if (drop_log[i] !== 4'b0000) begin n_bad++; $display("FAIL single_drop cyc %0d: got %b expected 0000", i, drop_log[i]); end
         if (ebusy) begin
            n_cmp++; if (src_log[i] !== 2'd0) begin n_bad++; $display("FAIL single_src cyc %0d: got %0d expected 0", i, src_log[i]); end
         end
      end
   endtask

   // rx1 and rx3 complete together: port 1 first, then port 3 after the gap.
   task automatic test_simul();
      logic [15:0] f1, f3;
      logic [3:0]  etx;
      logic        ebusy;
      logic [1:0]  esrc;
      do_reset(); clear_stim();
      put_frame(1, 0, 8'hC3);
      put_frame(3, 0, 8'h5A);
      run(60);
      f1 = 16'hABC3; f3 = 16'hAB5A;
      for (int i = 0; i < 60; i++) begin
         etx = 4'b0000;
         if (i >= 17 && i <= 32 && f1[15 - (i - 17)]) etx = 4'b1101;
         if (i >= 36 && i <= 51 && f3[15 - (i - 36)]) etx = 4'b0111;
         ebusy = (i >= 17 && i <= 34) || (i >= 36 && i <= 53);
         esrc  = (i >= 36) ? 2'd3 : 2'd1;
         n_cmp++; if (tx_log[i] !== etx) begin n_bad++; $display("FAIL simul_tx cyc %0d: got %b expected %b", i, tx_log[i], etx); end
         n_cmp++; if (busy_log[i] !== ebusy) begin n_bad++; $display("FAIL simul_busy cyc %0d: got %b expected %b", i, busy_log[i], ebusy); end
         n_cmp++; if (drop_log[i] !== 4'b0000) begin n_bad++; $display("FAIL simul_drop cyc %0d: got %b expected 0000", i, drop_log[i]); end
         if (ebusy) begin
            n_cmp++; if (src_log[i] !== esrc) begin n_bad++; $display("FAIL simul_src cyc %0d: got %0d expected %0d", i, src_log[i], esrc); end
         end
      end
   endtask

   // Port 0 transmits while rx2 completes twice; the second rx2 frame is dropped.
   task automatic test_drop();
      logic [15:0] f0, f2;
      logic [3:0]  etx, edrop;
      logic        ebusy;
      logic [1:0]  esrc;
      do_reset(); clear_stim();
      put_frame(0, 0, 8'h0F);
      put_frame(2, 2, 8'h33);
      put_frame(2, 18, 8'hCC);
      run(64);
      f0 = 16'hAB0F; f2 = 16'hAB33;
      for (int i = 0; i < 64; i++) begin
         etx = 4'b0000;
         if (i >= 17 && i <= 32 && f0[15 - (i - 17)]) etx = 4'b1110;
         if (i >= 36 && i <= 51 && f2[15 - (i - 36)]) etx = 4'b1011;
         ebusy = (i >= 17 && i <= 34) || (i >= 36 && i <= 53);
         esrc  = (i >= 36) ? 2'd2 : 2'd0;
         edrop = (i == 34) ? 4'b0100 : 4'b0000;
         n_cmp++; if (tx_log[i] !== etx) begin n_bad++; $display("FAIL drop_tx cyc %0d: got %b expected %b", i, tx_log[i], etx); end
         n_cmp++; if (busy_log[i] !== ebusy) begin n_bad++; $display("FAIL drop_busy cyc %0d: got %b expected %b", i, busy_log[i], ebusy); end
         n_cmp++; if (drop_log[i] !== edrop) begin n_bad++; $display("FAIL drop_pulse cyc %0d: got %b expected %b", i, drop_log[i], edrop); end
         if (ebusy) begin
            n_cmp++; if (src_log[i] !== esrc) begin n_bad++; $display("FAIL drop_src cyc %0d: got %0d expected %0d", i, src_log[i], esrc); end
         end
      end
   endtask

   // Port 0's second capture completes on the edge that grants its first frame.
   task automatic test_grant_edge();
      logic [15:0] f1, fa, fb;
      logic [3:0]  etx;
      logic        ebusy;
      logic [1:0]  esrc;
      do_reset(); clear_stim();
      put_frame(1, 0, 8'h81);
      put_frame(0, 1, 8'h96);
      put_frame(0, 20, 8'h3C);
      run(80);
      f1 = 16'hAB81; fa = 16'hAB96; fb = 16'hAB3C;
      for (int i = 0; i < 80; i++) begin
         etx = 4'b0000;
         if (i >= 17 && i <= 32 && f1[15 - (i - 17)]) etx = 4'b1101;
         if (i >= 36 && i <= 51 && fa[15 - (i - 36)]) etx = 4'b1110;
         if (i >= 55 && i <= 70 && fb[15 - (i - 55)]) etx = 4'b1110;
         ebusy = (i >= 17 && i <= 34) || (i >= 36 && i <= 53) || (i >= 55 && i <= 72);
         esrc  = (i >= 36) ? 2'd0 : 2'd1;
         n_cmp++; if (tx_log[i] !== etx) begin n_bad++; $display("FAIL gedge_tx cyc %0d: got %b expected %b", i, tx_log[i], etx); end
         n_cmp++; if (busy_log[i] !== ebusy) begin n_bad++; $display("FAIL gedge_busy cyc %0d: got %b expected %b", i, busy_log[i], ebusy); end
         n_cmp++; if (drop_log[i] !== 4'b0000) begin n_bad++; $display("FAIL gedge_drop cyc %0d: got %b expected 0000", i, drop_log[i]); end
         if (ebusy) begin
            n_cmp++; if (src_log[i] !== esrc) begin n_bad++; $display("FAIL gedge_src cyc %0d: got %0d expected %0d", i, src_log[i], esrc); end
         end
      end
   endtask

   // Port 2 sends, port 3 waits; reset sampled low at the 5th SEND cycle.
   task automatic test_reset_mid();
      do_reset(); clear_stim();
      put_frame(2, 0, 8'h0F);
      put_frame(3, 0, 8'h55);
      stim_rst[21] = 1'b0;
      run(50);
      n_cmp++; if (tx_log[21] !== 4'b1011) begin n_bad++; $display("FAIL rmid_pre_tx: got %b expected 1011", tx_log[21]); end
      n_cmp++; if (src_log[21] !== 2'd2) begin n_bad++; $display("FAIL rmid_pre_src: got %0d expected 2", src_log[21]); end
      for (int i = 22; i < 50; i++) begin
         n_cmp++; if (tx_log[i] !== 4'b0000) begin n_bad++; $display("FAIL rmid_tx cyc %0d: got %b expected 0000", i, tx_log[i]); end
         n_cmp++; if (busy_log[i] !== 1'b0) begin n_bad++; $display("FAIL rmid_busy cyc %0d: got %b expected 0", i, busy_log[i]); end
         n_cmp++; if (src_log[i] !== 2'd0) begin n_bad++; $display("FAIL rmid_src cyc %0d: got %0d expected 0", i, src_log[i]); end
         n_cmp++; if (drop_log[i] !== 4'b0000) begin n_bad++; $display("FAIL rmid_drop cyc %0d: got %b expected 0000", i, drop_log[i]); end
      end
   endtask

   // Alternating 1010... on rx0 never forms ...11, so no SFD is found.
   task automatic test_no_sfd();
      do_reset(); clear_stim();
      for (int i = 0; i < 40; i++) stim[i][0] = (i % 2 == 0);
      run(50);
      for (int i = 0; i < 50; i++) begin
         n_cmp++; if (tx_log[i] !== 4'b0000) begin n_bad++; $display("FAIL nosfd_tx cyc %0d: got %b expected 0000", i, tx_log[i]); end
         n_cmp++; if (busy_log[i] !== 1'b0) begin n_bad++; $display("FAIL nosfd_busy cyc %0d: got %b expected 0", i, busy_log[i]); end
         n_cmp++; if (drop_log[i] !== 4'b0000) begin n_bad++; $display("FAIL nosfd_drop cyc %0d: got %b expected 0000", i, drop_log[i]); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_simul();
      test_drop();
      test_grant_edge();
      test_reset_mid();
      test_no_sfd();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
